// File: rtl/cpu_ctrl_pkg.sv
// Shared control-path definitions for the microcode sequencer: state
// encodings, control-word bit positions and address widths.
package cpu_ctrl_pkg;

  localparam int OPC_W  = 4;
  localparam int ROM_AW = 8;
  localparam int CW_W   = 16;
  localparam int CW_HLT = 15;
  localparam int CW_SR  = 0;

  typedef enum logic [1:0] {
    S_ADDR = 2'd0,
    S_EXEC = 2'd1,
    S_HALT = 2'd2
  } seq_state_t;

  // A non-halting word ends its instruction when it carries step-reset,
  // is all zero, or is fetched at the last legal step.
  function automatic logic cw_ends_instr(input logic [CW_W-1:0] cw,
                                         input int              sr_bit,
                                         input logic            at_last);
    return cw[sr_bit] | (cw == '0) | at_last;
  endfunction

endpackage

// File: rtl/microstep_counter.sv
// Microstep counter: synchronous clear, increment, wrap to 0 after MAX_STEP.
// Clear has priority over increment.
module microstep_counter #(
  parameter int STEP_W   = 4,
  parameter int MAX_STEP = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_inc,
  output logic [STEP_W-1:0] o_step
);

  logic [STEP_W-1:0] r_step;
  logic              w_at_max;

  assign w_at_max = (r_step == STEP_W'(MAX_STEP));
  assign o_step   = r_step;

  // Step register: clear wins, otherwise count modulo MAX_STEP+1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step <= '0;
    end else if (i_clr) begin
      r_step <= '0;
    end else if (i_inc) begin
      if (w_at_max) r_step <= '0;
      else          r_step <= r_step + 1'b1;
    end
  end

endmodule

// File: rtl/microcode_sequencer.sv
// Microcode sequencer: forms the control-ROM address {opcode, step}, waits
// one cycle for the registered ROM, presents the returned control word for
// a single cycle and then advances, ends or halts the instruction.
// Optional feature macro: SEQ_SINGLE_STEP_EN adds step_mode/step_req so the
// sequencer can be walked one microstep per request pulse.
module microcode_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int STEP_W   = 4,
  parameter int MAX_STEP = 7,
  parameter int HLT_BIT  = CW_HLT,
  parameter int SR_BIT   = CW_SR
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [OPC_W-1:0]  opcode,
  input  logic              run,
  input  logic              clear_halt,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic              step_mode,
  input  logic              step_req,
`endif
  input  logic [CW_W-1:0]   ctrl_word,
  output logic [ROM_AW-1:0] rom_addr,
  output logic [CW_W-1:0]   ctrl_out,
  output logic              ctrl_valid,
  output logic              instr_done,
  output logic              halted,
  output logic [3:0]        step
);

  seq_state_t        r_state;
  seq_state_t        w_state_nxt;
  logic [STEP_W-1:0] w_step;
  logic              w_clr;
  logic              w_inc;
  logic              w_go;
  logic              w_at_last;

  // In single-step mode each request pulse releases exactly one fetch.
`ifdef SEQ_SINGLE_STEP_EN
  assign w_go = run & (~step_mode | step_req);
`else
  assign w_go = run;
`endif

  assign w_at_last = (w_step == STEP_W'(MAX_STEP));
  assign rom_addr  = {opcode, w_step};
  assign step      = 4'(w_step);

  microstep_counter #(
    .STEP_W   (STEP_W),
    .MAX_STEP (MAX_STEP)
  ) u_step_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_clr),
    .i_inc  (w_inc),
    .o_step (w_step)
  );

  // State register; reset discards any in-flight control word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_ADDR;
    else        r_state <= w_state_nxt;
  end

  // Next-state, step control and control-word gating.
  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    w_inc       = 1'b0;
    ctrl_out    = '0;
    ctrl_valid  = 1'b0;
    instr_done  = 1'b0;
    halted      = 1'b0;
    case (r_state)
      S_ADDR: begin
        if (w_go) w_state_nxt = S_EXEC;
      end
      S_EXEC: begin
        // The word is always driven for its one cycle, even a halting one.
        ctrl_out   = ctrl_word;
        ctrl_valid = 1'b1;
        if (ctrl_word[HLT_BIT]) begin
          w_state_nxt = S_HALT;
        end else if (cw_ends_instr(ctrl_word, SR_BIT, w_at_last)) begin
          w_clr       = 1'b1;
          instr_done  = 1'b1;
          w_state_nxt = S_ADDR;
        end else begin
          w_inc       = 1'b1;
          w_state_nxt = S_ADDR;
        end
      end
      S_HALT: begin
        halted = 1'b1;
        if (clear_halt) begin
          w_clr       = 1'b1;
          w_state_nxt = S_ADDR;
        end
      end
      default: begin
        w_clr       = 1'b1;
        w_state_nxt = S_ADDR;
      end
    endcase
  end

endmodule
